// File: rtl/score_pkg.sv
// Shared state encoding and game limits for the score keeper.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [3:0]  MAX_LIVES = 4'd9;
  localparam logic [3:0]  MAX_LEVEL = 4'd9;
  localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit of a ripple BCD adder: digit + addend + carry_in.
// Purely combinational; chained four times by score_keeper.
module bcd_digit_add (
  input  logic [3:0] digit,
  input  logic [3:0] addend,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [4:0] raw;

  always_comb begin
    raw = 5'(digit) + 5'(addend) + 5'(carry_in);
    if (raw > 5'd9) begin
      sum       = 4'(raw - 5'd10);
      carry_out = 1'b1;
    end else begin
      sum       = raw[3:0];
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Breakout score keeper: edge-detected game events update BCD score, lives and level.
// Latency: one clock from a sampled input edge to the registered outputs; no backpressure.
module score_keeper
  import score_pkg::*;
#(
  parameter int POINTS          = 1,
  parameter int START_LIVES     = 3,
  parameter int BONUS_EVERY_100 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        brick_hit,
  input  logic        ball_lost,
  input  logic        level_clear,
  output logic [15:0] score_bcd,
  output logic [3:0]  lives,
  output logic [3:0]  level,
  output logic        game_over,
  output logic        playing
);

  localparam logic [15:0] ADDEND_VEC = {12'd0, 4'(POINTS)};

  state_t      state, state_n;
  logic [15:0] score_n, score_add, digit_sum;
  logic [3:0]  lives_n, level_n;
  logic [4:0]  carry;
  logic [4:0]  net_lives;
  logic [3:0]  in_now, prev, ev;
  logic        armed;
  logic        add_life;

  // The first cycle after reset only primes the edge detectors, so inputs
  // already high at release never count as events.
  assign in_now = {new_game, brick_hit, ball_lost, level_clear};
  assign ev     = armed ? (in_now & ~prev) : 4'b0000;

  assign carry[0] = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_add u_digit (
      .digit     (score_bcd[4*i +: 4]),
      .addend    (ADDEND_VEC[4*i +: 4]),
      .carry_in  (carry[i]),
      .sum       (digit_sum[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  assign score_add = carry[4] ? SCORE_MAX : digit_sum;
  // Hundreds or thousands digit moved means a hundred boundary was crossed.
  assign add_life  = ev[2] && (BONUS_EVERY_100 != 0) &&
                     (score_add[15:8] != score_bcd[15:8]);

  always_comb begin
    state_n   = state;
    score_n   = score_bcd;
    lives_n   = lives;
    level_n   = level;
    net_lives = 5'(lives) + 5'(add_life) - 5'(ev[1]);
    case (state)
      IDLE, OVER: begin
        if (ev[3]) begin
          state_n = PLAY;
          score_n = 16'h0000;
          lives_n = 4'(START_LIVES);
          level_n = 4'd1;
        end
      end
      PLAY: begin
        if (ev[2]) score_n = score_add;
        lives_n = (net_lives > 5'(MAX_LIVES)) ? MAX_LIVES : net_lives[3:0];
        if (ev[0] && (level < MAX_LEVEL)) level_n = level + 4'd1;
        if (net_lives == 5'd0) state_n = OVER;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      score_bcd <= 16'h0000;
      lives     <= 4'd0;
      level     <= 4'd0;
      prev      <= 4'b0000;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      score_bcd <= score_n;
      lives     <= lives_n;
      level     <= level_n;
      prev      <= in_now;
      armed     <= 1'b1;
    end
  end

  assign game_over = (state == OVER);
  assign playing   = (state == PLAY);

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter POINTS, default 1, BCD points added per brick hit (legal 1..9).
REQ-002 Parameter START_LIVES, default 3, lives loaded at game start (legal 1..9).
REQ-003 Parameter BONUS_EVERY_100, default 1, SHALL award one life each time the score's hundreds digit increments when set to 1; bonus disabled when set to 0.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 new_game  input  1  level request to start or restart a game.
REQ-007 brick_hit  input  1  level, high while ball overlaps a brick.
REQ-008 ball_lost  input  1  level, high while ball is below paddle.
REQ-009 level_clear  input  1  level, high when all bricks are gone.
REQ-010 score_bcd  output  16  four BCD digits; [3:0] ones ... [15:12] thousands; each nibble drives one 7-segment decoder.
REQ-011 lives  output  4  remaining lives, binary 0..9.
REQ-012 level  output  4  current level, binary 1..9.
REQ-013 game_over  output  1  high while in OVER state.
REQ-014 playing  output  1  high while in PLAY state.

Function
REQ-015 Each of new_game, brick_hit, ball_lost and level_clear SHALL be rising-edge detected against a registered copy; one assertion counts once, however long it is held.
REQ-016 The FSM states are IDLE, PLAY and OVER.
- IDLE -> PLAY on a new_game edge.
- PLAY -> OVER when lives reach 0.
- OVER -> PLAY on a new_game edge.
REQ-017 Entry to PLAY SHALL load score_bcd=0, lives=START_LIVES and level=1 on the same edge as the state change.
REQ-018 Latency: an input edge sampled at clock edge N SHALL be reflected in the outputs immediately after edge N; no further delay.
REQ-019 In PLAY, a brick_hit edge SHALL add POINTS to score_bcd with decimal carry between digits.
REQ-020 The score SHALL saturate at 9999; a carry out of the thousands digit is not allowed.
REQ-021 In PLAY, a ball_lost edge SHALL decrement lives by 1.
REQ-022 When lives would go from 1 to 0, the block SHALL enter OVER on that edge with lives=0.
REQ-023 In PLAY, a level_clear edge SHALL increment level, saturating at 9.
REQ-024 Bonus (BONUS_EVERY_100=1): when an add changes the hundreds digit, or carries into thousands, lives SHALL increment by 1, saturating at 9.
REQ-025 Simultaneous events in one cycle SHALL all apply:
- Score is updated first.
- Net lives = lives + bonus - lost.
- OVER is entered only if net lives = 0.
REQ-026 In IDLE and OVER, brick_hit, ball_lost and level_clear SHALL be ignored and all outputs held.
REQ-027 A new_game edge during PLAY SHALL be ignored.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL set:
- state=IDLE
- score_bcd=0, lives=0, level=0
- game_over=0, playing=0
- all edge-detect registers=0
REQ-029 Reset mid-game SHALL discard all progress; no event edge is generated by inputs that are already high at reset release.

Structure
REQ-030 A shared package (score_pkg) SHALL hold the state encoding (IDLE=2'd0, PLAY=2'd1, OVER=2'd2) and the constants MAX_LIVES=9, MAX_LEVEL=9 and SCORE_MAX=16'h9999.
REQ-031 One sub-module, bcd_digit_add, SHALL be instantiated four times in a chain.
- Inputs: 4-bit digit, 4-bit addend, carry in.
- Outputs: sum digit, carry out.
REQ-032 Outputs SHALL be registered; no combinational path from any input to any output.

Verification
REQ-033 Start and count: reset, then new_game pulse, then 12 brick_hit pulses (POINTS=1) -> playing=1, score_bcd=16'h0012, lives=3, level=1.
REQ-034 Held input: brick_hit held high for 50 cycles -> score increments exactly once.
REQ-035 Bonus and saturation: preload via hits to 0099, then one hit -> score_bcd=16'h0100, lives=4; continue to 9999, then one more hit -> score stays 16'h9999.
REQ-036 Game over and restart: with lives=1, a ball_lost edge -> next cycle game_over=1, lives=0; further hits are ignored; new_game -> score=0, lives=3, playing=1.
REQ-037 Simultaneous events: at score 0199 with lives=1, brick_hit and ball_lost in the same cycle -> score=0200, lives=1, state remains PLAY.
REQ-038 Reset mid-game: at score 0042 with all inputs high, assert rst for 1 cycle -> state=IDLE, all outputs 0, no increment after release.
